// File: rtl/tcam_match_walker.sv
// tcam_match_walker: captures a TCAM hit vector and hands out the index of
// every matching entry, lowest address first, over a ready/valid interface.
// Also reports the hit count, flags the final hit and pulses miss on an
// all-zero vector.
module tcam_match_walker #(
  parameter int unsigned ENTRIES = 20,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ENTRIES-1:0] matched,
  input  logic               match_valid,
  output logic               busy,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [ADDR_W-1:0]  hit_addr,
  output logic               hit_last,
  output logic [ADDR_W-1:0]  hit_count,
  output logic               miss
);

  typedef enum logic [0:0] {StIdle, StWalk} state_e;

  state_e             state_q;
  logic [ENTRIES-1:0] pending_q;
  logic [ADDR_W-1:0]  hit_count_q;
  logic               miss_q;

  logic [ENTRIES-1:0] pending_clr;
  logic [ADDR_W-1:0]  low_idx;
  logic               one_left;
  logic [ADDR_W-1:0]  capture_count;
  logic               handshake;

  // Index of the lowest set bit; scanning downward lets the lowest win.
  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [ENTRIES-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (v[i]) idx = ADDR_W'(i);
    end
    return idx;
  endfunction

  // Number of set bits in the hit vector.
  function automatic logic [ADDR_W-1:0] popcount(input logic [ENTRIES-1:0] v);
    logic [ADDR_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      cnt = cnt + ADDR_W'(v[i]);
    end
    return cnt;
  endfunction

  // Lookup decode of the pending vector: next hit, last-hit flag, cleared vector.
  always_comb begin
    low_idx       = lowest_idx(pending_q);
    // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
    pending_clr   = pending_q & (pending_q - ENTRIES'(1));
    one_left      = (pending_q != '0) && (pending_clr == '0);
    capture_count = popcount(matched);
    handshake     = (state_q == StWalk) && hit_ready;
  end

  // Walker FSM: capture in idle, drain one hit per accepted handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      hit_count_q <= '0;
      miss_q      <= 1'b0;
    end else begin
      miss_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (match_valid) begin
            pending_q   <= matched;
            hit_count_q <= capture_count;
            if (matched == '0) begin
              miss_q <= 1'b1;
            end else begin
              state_q <= StWalk;
            end
          end
        end
        StWalk: begin
          // match_valid is deliberately ignored here, including on the final handshake.
          if (handshake) begin
            pending_q <= pending_clr;
            if (one_left) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs derive from registered state only; idle keeps pending at zero so
  // hit_addr and hit_last read zero outside a walk.
  always_comb begin
    busy      = (state_q == StWalk);
    hit_valid = (state_q == StWalk);
    hit_addr  = (state_q == StWalk) ? low_idx : '0;
    hit_last  = (state_q == StWalk) && one_left;
    hit_count = hit_count_q;
    miss      = miss_q;
  end

endmodule

// File: tb/tb_tcam_match_walker.sv
// Self-checking bench for tcam_match_walker: table of lookups with a
// scoreboard of expected hits, plus hand-written reset-mid-walk sequence.
module tb_tcam_match_walker;

  localparam int ENTRIES = 20;
  localparam int ADDR_W  = 5;

  logic               clk;
  logic               reset;
  logic [ENTRIES-1:0] matched;
  logic               match_valid;
  logic               busy;
  logic               hit_valid;
  logic               hit_ready;
  logic [ADDR_W-1:0]  hit_addr;
  logic               hit_last;
  logic [ADDR_W-1:0]  hit_count;
  logic               miss;

  tcam_match_walker #(
    .ENTRIES(ENTRIES),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .matched    (matched),
    .match_valid(match_valid),
    .busy       (busy),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_addr   (hit_addr),
    .hit_last   (hit_last),
    .hit_count  (hit_count),
    .miss       (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ENTRIES-1:0] vec;
    int                 stall;
    bit                 inject;
    int                 exp_count;
    int                 exp_first;
    int                 exp_last;
  } vec_t;

  typedef struct {
    int addr;
    bit last;
  } hit_t;

  hit_t q[$];
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one lookup at a negedge and drains it; returns at a negedge.
  task automatic lookup(input vec_t v);
    int exp_n;
    int busy_cyc;
    int guard;
    int stall;
    int first_seen;
    int last_seen;
    exp_n = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (v.vec[i]) begin
        q.push_back('{addr: i, last: 1'b0});
        exp_n++;
      end
    end
    if (exp_n > 0) q[q.size() - 1].last = 1'b1;
    chk("idle_before_lookup", int'(busy), 0);
    matched     = v.vec;
    match_valid = 1'b1;
    hit_ready   = 1'b0;
    @(negedge clk);
    match_valid = v.inject;
    matched     = v.inject ? ENTRIES'(20'h00008) : '0;
    if (exp_n == 0) begin
      chk("miss_pulse", int'(miss), 1);
      chk("miss_hit_valid", int'(hit_valid), 0);
      chk("miss_busy", int'(busy), 0);
      chk("miss_count", int'(hit_count), v.exp_count);
      match_valid = 1'b0;
      return;
    end
    busy_cyc   = 0;
    guard      = 0;
    stall      = v.stall;
    first_seen = -1;
    last_seen  = -1;
    while (q.size() > 0 && guard < 200) begin
      guard++;
      chk("hit_valid", int'(hit_valid), 1);
      chk("hit_addr", int'(hit_addr), q[0].addr);
      chk("hit_last", int'(hit_last), int'(q[0].last));
      chk("hit_count", int'(hit_count), v.exp_count);
      chk("no_miss_in_walk", int'(miss), 0);
      if (first_seen < 0) first_seen = int'(hit_addr);
      if (hit_last) last_seen = int'(hit_addr);
      if (busy) busy_cyc++;
      if (stall > 0) begin
        hit_ready = 1'b0;
        stall--;
      end else begin
        hit_ready = 1'b1;
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    if (q.size() > 0) begin
      chk("walk_timeout", q.size(), 0);
      q.delete();
    end
    match_valid = 1'b0;
    matched     = '0;
    hit_ready   = 1'b0;
    chk("first_addr", first_seen, v.exp_first);
    chk("last_addr", last_seen, v.exp_last);
    chk("busy_cycles", busy_cyc, v.exp_count + v.stall);
    chk("busy_dropped", int'(busy), 0);
    chk("hit_valid_dropped", int'(hit_valid), 0);
    @(negedge clk);
    chk("no_capture_after", int'(busy), 0);
    chk("count_held", int'(hit_count), v.exp_count);
    chk("miss_quiet", int'(miss), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_hit_valid"}, int'(hit_valid), 0);
    chk({tag, "_hit_addr"}, int'(hit_addr), 0);
    chk({tag, "_hit_last"}, int'(hit_last), 0);
    chk({tag, "_hit_count"}, int'(hit_count), 0);
    chk({tag, "_miss"}, int'(miss), 0);
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    tbl[0] = '{vec: 20'h00010, stall: 0, inject: 0, exp_count: 1,  exp_first: 4, exp_last: 4};
    tbl[1] = '{vec: 20'h00070, stall: 2, inject: 0, exp_count: 3,  exp_first: 4, exp_last: 6};
    tbl[2] = '{vec: 20'h00000, stall: 0, inject: 0, exp_count: 0,  exp_first: 0, exp_last: 0};
    tbl[3] = '{vec: 20'h00001, stall: 0, inject: 0, exp_count: 1,  exp_first: 0, exp_last: 0};
    tbl[4] = '{vec: 20'h80001, stall: 0, inject: 0, exp_count: 2,  exp_first: 0, exp_last: 19};
    tbl[5] = '{vec: 20'hFFFFF, stall: 0, inject: 0, exp_count: 20, exp_first: 0, exp_last: 19};
    tbl[6] = '{vec: 20'h00070, stall: 0, inject: 1, exp_count: 3,  exp_first: 4, exp_last: 6};
    tbl[7] = '{vec: 20'h00070, stall: 1, inject: 1, exp_count: 3,  exp_first: 4, exp_last: 6};
    tbl[8] = '{vec: 20'h5A5A5, stall: 3, inject: 0, exp_count: 10, exp_first: 0, exp_last: 18};

    reset       = 1'b1;
    matched     = '0;
    match_valid = 1'b0;
    hit_ready   = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // hit_ready in idle must have no effect.
    hit_ready = 1'b1;
    @(negedge clk);
    hit_ready = 1'b0;
    check_all_zero("idle_ready");

    // Entry 2 (miss) is followed back-to-back by entry 3.
    for (int i = 0; i < 9; i++) lookup(tbl[i]);

    // Reset in the middle of a walk of 20'h00070.
    matched     = 20'h00070;
    match_valid = 1'b1;
    @(negedge clk);
    match_valid = 1'b0;
    matched     = '0;
    chk("rst_walk_first", int'(hit_addr), 4);
    hit_ready = 1'b1;
    @(negedge clk);
    chk("rst_walk_second", int'(hit_addr), 5);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    hit_ready = 1'b0;
    #3;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_release");
    v = '{vec: 20'h00200, stall: 0, inject: 0, exp_count: 1, exp_first: 9, exp_last: 9};
    lookup(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "time limit");
  end

endmodule
